// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a serial TDM stream. Each bit group is steered
// into its channel register, and the channel is announced with a one-cycle
// valid pulse.
module tdm_demux #(
   parameter int NUM_CH   = 2,
   parameter int CH_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       din,
   input  logic                       fsync,
   output logic [NUM_CH*CH_WIDTH-1:0] ch_data,
   output logic [NUM_CH-1:0]          ch_valid,
   output logic                       frame_done,
   output logic                       sync_err,
   output logic                       busy
);

   localparam int BW = (CH_WIDTH > 1) ? $clog2(CH_WIDTH) : 1;
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(CH_WIDTH - 1);
   localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);

   typedef enum logic {IDLE, RECV} state_t;

   state_t                      state_q, state_d;
   logic [BW-1:0]               bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]               ch_cnt_q, ch_cnt_d;
   logic [CH_WIDTH-1:0]         shift_q, shift_d;
   logic [NUM_CH*CH_WIDTH-1:0]  ch_data_q, ch_data_d;
   logic [NUM_CH-1:0]           ch_valid_q, ch_valid_d;
   logic                        frame_done_q, frame_done_d;
   logic                        sync_err_q, sync_err_d;
   logic                        busy_q, busy_d;

   logic                        sampling;
   logic [BW-1:0]               cur_bit;
   logic [CW-1:0]               cur_ch;
   logic [CH_WIDTH-1:0]         word;

   // Next state: fsync always restarts at bit 0 of channel 0, whether the
   // block is idle (legal start) or mid-frame (resync with error pulse).
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      ch_cnt_d     = ch_cnt_q;
      shift_d      = shift_q;
      ch_data_d    = ch_data_q;
      ch_valid_d   = '0;
      frame_done_d = 1'b0;
      sync_err_d   = (state_q == RECV) && fsync;

      sampling = (state_q == RECV) || fsync;
      cur_bit  = fsync ? '0 : bit_cnt_q;
      cur_ch   = fsync ? '0 : ch_cnt_q;
      word     = (shift_q << 1) | CH_WIDTH'(din);

      if (sampling) begin
         shift_d = word;
         state_d = RECV;
         if (cur_bit == LAST_BIT) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
               if (cur_ch == CW'(k)) begin
                  ch_data_d[k*CH_WIDTH +: CH_WIDTH] = word;
                  ch_valid_d[k]                     = 1'b1;
               end
            end
            bit_cnt_d = '0;
            if (cur_ch == LAST_CH) begin
               frame_done_d = 1'b1;
               ch_cnt_d     = '0;
               state_d      = IDLE;
            end else begin
               ch_cnt_d = cur_ch + CW'(1);
            end
         end else begin
            bit_cnt_d = cur_bit + BW'(1);
            ch_cnt_d  = cur_ch;
         end
      end

      busy_d = (state_d == RECV);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         ch_cnt_q     <= '0;
         shift_q      <= '0;
         ch_data_q    <= '0;
         ch_valid_q   <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         ch_cnt_q     <= ch_cnt_d;
         shift_q      <= shift_d;
         ch_data_q    <= ch_data_d;
         ch_valid_q   <= ch_valid_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
         busy_q       <= busy_d;
      end
   end

   assign ch_data    = ch_data_q;
   assign ch_valid   = ch_valid_q;
   assign frame_done = frame_done_q;
   assign sync_err   = sync_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for two tdm_demux configurations
// (2 x 4-bit and 4 x 8-bit). Expected pulses are derived from whole frames.
module tb_tdm_demux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  valid;
      logic        fd;
      logic        se;
   } ev_t;

   ev_t qa[$];
   ev_t qb[$];
   int  errors = 0;
   int  checks = 0;
   int  fd_cnt_a = 0;
   int  se_cnt_a = 0;

   // 2 x 4 instance
   logic       rst_a = 1'b1, din_a = 1'b0, fsync_a = 1'b0;
   logic [7:0] data_a;
   logic [1:0] valid_a;
   logic       fd_a, se_a, busy_a;

   // 4 x 8 instance
   logic        rst_b = 1'b1, din_b = 1'b0, fsync_b = 1'b0;
   logic [31:0] data_b;
   logic [3:0]  valid_b;
   logic        fd_b, se_b, busy_b;

   tdm_demux #(.NUM_CH(2), .CH_WIDTH(4)) u_a (
      .clk(clk), .rst(rst_a), .din(din_a), .fsync(fsync_a),
      .ch_data(data_a), .ch_valid(valid_a), .frame_done(fd_a),
      .sync_err(se_a), .busy(busy_a)
   );

   tdm_demux #(.NUM_CH(4), .CH_WIDTH(8)) u_b (
      .clk(clk), .rst(rst_b), .din(din_b), .fsync(fsync_b),
      .ch_data(data_b), .ch_valid(valid_b), .frame_done(fd_b),
      .sync_err(se_b), .busy(busy_b)
   );

   // Reference state: delivered channel words and pending-resync flag.
   logic [7:0]  ma = '0;
   logic [31:0] mb = '0;
   bit          a_partial = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [3:0] v, input logic fd, input logic se);
      ev_t e;
      e.data = 32'(ma); e.valid = v; e.fd = fd; e.se = se;
      qa.push_back(e);
   endtask

   // Sends the first nbits of a frame (bits[7] first). A truncated frame must
   // be followed directly by another frame, whose fsync then is a resync.
   task automatic frame_a(input logic [7:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         din_a   = bits[7-i];
         fsync_a = (i == 0);
         if (i == 0 && a_partial) push_a(4'b0000, 1'b0, 1'b1);
         if (i % 4 == 3) begin
            ma[4*(i/4) +: 4] = bits[7-4*(i/4) -: 4];
            push_a(4'(1 << (i/4)), (i/4) == 1, 1'b0);
         end
         tick();
      end
      a_partial = (nbits < 8);
      din_a   = 1'b0;
      fsync_a = 1'b0;
      chk("a_busy_after_frame", 32'(busy_a), 32'(nbits < 8));
   endtask

   task automatic frame_b(input logic [31:0] bits);
      ev_t e;
      for (int i = 0; i < 32; i++) begin
         din_b   = bits[31-i];
         fsync_b = (i == 0);
         if (i % 8 == 7) begin
            mb[8*(i/8) +: 8] = bits[31-8*(i/8) -: 8];
            e.data = mb; e.valid = 4'(1 << (i/8)); e.fd = ((i/8) == 3); e.se = 1'b0;
            qb.push_back(e);
         end
         tick();
      end
      din_b   = 1'b0;
      fsync_b = 1'b0;
   endtask

   // Monitor A: any pulse must match the next expected event.
   always @(negedge clk) begin
      ev_t e;
      if (valid_a !== 2'b00 || fd_a !== 1'b0 || se_a !== 1'b0) begin
         fd_cnt_a += (fd_a === 1'b1) ? 1 : 0;
         se_cnt_a += (se_a === 1'b1) ? 1 : 0;
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected: got valid=%b fd=%b se=%b expected no pulse", valid_a, fd_a, se_a);
         end else begin
            e = qa.pop_front();
            chk("a_valid", 32'(valid_a), 32'(e.valid));
            chk("a_frame_done", 32'(fd_a), 32'(e.fd));
            chk("a_sync_err", 32'(se_a), 32'(e.se));
            chk("a_data", 32'(data_a), e.data);
         end
      end
   end

   // Monitor B.
   always @(negedge clk) begin
      ev_t e;
      if (valid_b !== 4'b0000 || fd_b !== 1'b0 || se_b !== 1'b0) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected: got valid=%b fd=%b se=%b expected no pulse", valid_b, fd_b, se_b);
         end else begin
            e = qb.pop_front();
            chk("b_valid", 32'(valid_b), 32'(e.valid));
            chk("b_frame_done", 32'(fd_b), 32'(e.fd));
            chk("b_sync_err", 32'(se_b), 32'(e.se));
            chk("b_data", data_b, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] prev;
      int         fd0;
      tick();
      tick();
      rst_a = 1'b0;
      rst_b = 1'b0;
      chk("a_reset_data", 32'(data_a), 32'h0);
      chk("a_reset_valid", 32'(valid_a), 32'h0);
      chk("a_reset_busy", 32'(busy_a), 32'h0);
      chk("b_reset_data", data_b, 32'h0);

      // Basic frame: ch0=A, ch1=6.
      frame_a(8'b1010_0110, 8);
      tick();
      chk("a_basic_data", 32'(data_a), 32'h6A);

      // Back-to-back frames.
      fd0 = fd_cnt_a;
      frame_a(8'b1010_0110, 8);
      frame_a(8'b1111_0001, 8);
      tick();
      chk("a_b2b_data", 32'(data_a), 32'h1F);
      chk("a_b2b_frame_done_count", 32'(fd_cnt_a - fd0), 32'd2);
      chk("a_b2b_sync_err_count", 32'(se_cnt_a), 32'd0);

      // Resync on bit 6: ch0 delivered, ch1 discarded, new frame follows.
      frame_a(8'b1010_1100, 6);
      frame_a(8'b0011_0101, 8);
      tick();
      chk("a_resync_sync_err_count", 32'(se_cnt_a), 32'd1);
      chk("a_resync_data", 32'(data_a), 32'h53);

      // Idle noise with fsync low.
      prev = data_a;
      for (int i = 0; i < 20; i++) begin
         din_a = 1'($urandom);
         tick();
         chk("a_idle_busy", 32'(busy_a), 32'h0);
      end
      din_a = 1'b0;
      chk("a_idle_data", 32'(data_a), 32'(prev));

      // Reset on bit 3 of a frame.
      frame_a(8'b1100_1010, 3);
      rst_a = 1'b1;
      din_a = 1'b0;
      tick();
      rst_a = 1'b0;
      a_partial = 1'b0;
      ma = '0;
      chk("a_rst_data", 32'(data_a), 32'h0);
      chk("a_rst_valid", 32'(valid_a), 32'h0);
      chk("a_rst_frame_done", 32'(fd_a), 32'h0);
      chk("a_rst_busy", 32'(busy_a), 32'h0);
      frame_a(8'b0111_1001, 8);
      tick();
      chk("a_post_rst_data", 32'(data_a), 32'h97);

      // Random frames on the wide instance, with random idle gaps.
      for (int f = 0; f < 20; f++) begin
         frame_b($urandom);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            din_b = 1'($urandom);
            tick();
         end
      end
      tick();
      tick();
      chk("b_final_data", data_b, mb);
      chk("a_queue_empty", 32'(qa.size()), 32'h0);
      chk("b_queue_empty", 32'(qb.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
